// File: rtl/sysid_checker_pkg.sv
// sysid_checker_pkg: shared states, addresses and counter widths for sysid_checker
package sysid_checker_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_REQ_ID = 3'd1;
  localparam state_t S_LAT_ID = 3'd2;
  localparam state_t S_REQ_TS = 3'd3;
  localparam state_t S_LAT_TS = 3'd4;
  localparam state_t S_CHECK  = 3'd5;
  localparam state_t S_DONE   = 3'd6;
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;
  localparam int TO_W  = 8;
  localparam int RT_W  = 3;
  localparam int LAT_W = 2;
endpackage

// File: rtl/sysid_checker_avm_read_timeout.sv
// avm_read_timeout: per-attempt waitrequest stall counter with expire pulse
module avm_read_timeout
  import sysid_checker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic stall,
  output logic expire
);
  logic [TO_W-1:0] cnt;
  assign expire = stall && (cnt == TO_W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= (stall && !expire) ? cnt + TO_W'(1) : '0;
endmodule

// File: rtl/sysid_checker.sv
// sysid_checker: boot-time Avalon-MM reader comparing system-ID and timestamp words
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1361488137,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);
  state_t           state;
  logic [RT_W-1:0]  retry;
  logic [LAT_W-1:0] lat_cnt;
  logic             auto_pend;
  logic             expire;
  logic             is_id;
  logic             is_req;
  logic             lat_last;
  logic             retry_max;
  logic             cap;
  assign is_id     = (state == S_REQ_ID) || (state == S_LAT_ID);
  assign is_req    = (state == S_REQ_ID) || (state == S_REQ_TS);
  assign lat_last  = lat_cnt == LAT_W'(READ_LATENCY - 1);
  assign retry_max = retry == RT_W'(MAX_RETRIES);
  assign cap       = (READ_LATENCY == 0) ? (is_req && avm_read && !avm_waitrequest)
                                         : ((state == S_LAT_ID || state == S_LAT_TS) && lat_last);
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = state == S_DONE;
  avm_read_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock  (clock),
    .reset_n(reset_n),
    .stall  (avm_read && avm_waitrequest),
    .expire (expire)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      captured_id <= '0;
      captured_ts <= '0;
    end else if (cap) begin
      if (is_id) captured_id <= avm_readdata;
      else captured_ts <= avm_readdata;
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state       <= S_IDLE;
      avm_read    <= 1'b0;
      avm_address <= ADDR_ID;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      retry       <= '0;
      lat_cnt     <= '0;
      auto_pend   <= AUTO_START;
    end else begin
      auto_pend <= 1'b0;
      case (state)
        S_IDLE, S_DONE:
          if (start || (auto_pend && state == S_IDLE)) begin
            state       <= S_REQ_ID;
            avm_read    <= 1'b1;
            avm_address <= ADDR_ID;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            retry       <= '0;
          end
        S_REQ_ID, S_REQ_TS:
          if (expire) begin
            avm_read    <= 1'b0;
            retry       <= retry_max ? retry : retry + RT_W'(1);
            timeout_err <= retry_max;
            state       <= retry_max ? S_DONE : state;
          end else if (!avm_read) avm_read <= 1'b1;
          else if (!avm_waitrequest) begin
            if (READ_LATENCY == 0) begin
              state       <= is_id ? S_REQ_TS : S_CHECK;
              avm_read    <= is_id;
              avm_address <= ADDR_TS;
            end else begin
              state    <= is_id ? S_LAT_ID : S_LAT_TS;
              avm_read <= 1'b0;
            end
          end
        S_LAT_ID, S_LAT_TS:
          if (lat_last) begin
            lat_cnt     <= '0;
            state       <= is_id ? S_REQ_TS : S_CHECK;
            avm_read    <= is_id;
            avm_address <= ADDR_TS;
          end else lat_cnt <= lat_cnt + LAT_W'(1);
        S_CHECK: begin
          id_ok <= captured_id == EXPECTED_ID;
          ts_ok <= captured_ts == EXPECTED_TS;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: directed checks of sysid_checker across latency, stall, timeout and reset cases
module tb_sysid_checker;
  localparam logic [31:0] TS = 32'd1361488137;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int passed = 0;
  always #5 clock = ~clock;

  logic        start0 = 1'b0, wait0 = 1'b0;
  logic [31:0] id_val = 32'd0;
  logic        addr0, read0, busy0, done0, idok0, tsok0, toe0;
  logic [31:0] rdata0, cid0, cts0;
  assign rdata0 = addr0 ? TS : id_val;
  sysid_checker u0 (
    .clock(clock), .reset_n(reset_n), .start(start0), .avm_address(addr0), .avm_read(read0),
    .avm_waitrequest(wait0), .avm_readdata(rdata0), .busy(busy0), .done(done0), .id_ok(idok0),
    .ts_ok(tsok0), .timeout_err(toe0), .captured_id(cid0), .captured_ts(cts0)
  );

  logic        start1 = 1'b0;
  logic        addr1, read1, busy1, done1, idok1, tsok1, toe1;
  logic [31:0] cid1, cts1;
  sysid_checker #(.TIMEOUT_CYCLES(4), .MAX_RETRIES(1), .AUTO_START(1'b0)) u1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .avm_address(addr1), .avm_read(read1),
    .avm_waitrequest(1'b1), .avm_readdata(32'd0), .busy(busy1), .done(done1), .id_ok(idok1),
    .ts_ok(tsok1), .timeout_err(toe1), .captured_id(cid1), .captured_ts(cts1)
  );

  logic        start2 = 1'b0;
  logic        addr2, read2, busy2, done2, idok2, tsok2, toe2;
  logic [31:0] rdata2, cid2, cts2;
  logic [1:0]  pv;
  logic [1:0]  pa;
  always @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      pv <= 2'b00;
      pa <= 2'b00;
    end else begin
      pv <= {pv[0], read2};
      pa <= {pa[0], addr2};
    end
  assign rdata2 = pv[1] ? (pa[1] ? TS : 32'd0) : 32'hDEADBEEF;
  sysid_checker #(.READ_LATENCY(2), .AUTO_START(1'b0)) u2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .avm_address(addr2), .avm_read(read2),
    .avm_waitrequest(1'b0), .avm_readdata(rdata2), .busy(busy2), .done(done2), .id_ok(idok2),
    .ts_ok(tsok2), .timeout_err(toe2), .captured_id(cid2), .captured_ts(cts2)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial begin
    #3;
    chk("rst read", read0, 0);
    chk("rst busy", busy0, 0);
    chk("rst done", done0, 0);
    chk("rst flags", {idok0, tsok0, toe0}, 0);
    chk("rst cid", cid0, 0);
    chk("rst cts", cts0, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick;
    chk("t1 c1 read", read0, 1);
    chk("t1 c1 addr", addr0, 0);
    chk("t1 c1 busy", busy0, 1);
    tick;
    chk("t1 c2 read", read0, 1);
    chk("t1 c2 addr", addr0, 1);
    tick;
    chk("t1 c3 read", read0, 0);
    chk("t1 c3 busy", busy0, 1);
    chk("t1 c3 done", done0, 0);
    tick;
    chk("t1 c4 done", done0, 1);
    chk("t1 c4 busy", busy0, 0);
    chk("t1 c4 flags", {idok0, tsok0, toe0}, 3'b110);
    chk("t1 c4 cts", cts0, TS);

    id_val = 32'h00000001;
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    chk("t2 c1 cleared", {idok0, tsok0, toe0}, 0);
    chk("t2 c1 read", read0, 1);
    tick;
    tick;
    tick;
    chk("t2 c4 done", done0, 1);
    chk("t2 flags", {idok0, tsok0, toe0}, 3'b010);
    chk("t2 cid", cid0, 32'h00000001);

    id_val = 32'd0;
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      wait0 = (c >= 1 && c <= 3) || (c >= 5 && c <= 7);
      chk($sformatf("t3 c%0d read", c), read0, (c <= 8) ? 1 : 0);
      if (c <= 8) chk($sformatf("t3 c%0d addr", c), addr0, (c <= 4) ? 0 : 1);
      chk($sformatf("t3 c%0d done", c), done0, (c == 10) ? 1 : 0);
      if (c < 10) tick;
    end
    wait0 = 1'b0;
    chk("t3 flags", {idok0, tsok0, toe0}, 3'b110);

    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("t4 c%0d read", c), read1, ((c >= 1 && c <= 4) || (c >= 6 && c <= 9)) ? 1 : 0);
      chk($sformatf("t4 c%0d done", c), done1, (c == 10) ? 1 : 0);
      if (c < 10) tick;
    end
    chk("t4 addr", addr1, 0);
    chk("t4 flags", {idok1, tsok1, toe1}, 3'b001);

    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("t5 c%0d read", c), read2, (c == 1 || c == 4) ? 1 : 0);
      chk($sformatf("t5 c%0d done", c), done2, (c == 8) ? 1 : 0);
      if (c < 8) tick;
    end
    chk("t5 cid", cid2, 32'd0);
    chk("t5 cts", cts2, TS);
    chk("t5 flags", {idok2, tsok2, toe2}, 3'b110);

    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    tick;
    wait0 = 1'b1;
    start0 = 1'b1;
    chk("t6 c2 addr", addr0, 1);
    tick;
    start0 = 1'b0;
    chk("t6 ignored start read", read0, 1);
    chk("t6 ignored start addr", addr0, 1);
    chk("t6 ignored start busy", busy0, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6 async read drop", read0, 0);
    chk("t6 async busy", busy0, 0);
    chk("t6 async cts", cts0, 0);
    wait0 = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick;
    chk("t6 rerun c1 read", read0, 1);
    tick;
    tick;
    tick;
    chk("t6 rerun done", done0, 1);
    chk("t6 rerun flags", {idok0, tsok0, toe0}, 3'b110);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
